// File: rtl/cdc_clear_sequencer.sv
// cdc_clear_sequencer
// One side of a lock-stepped clear sequence for a two-sided clock domain
// crossing. Two instances, one per clock domain, exchange their Gray-coded
// state over async_state_o/async_state_i and walk both CDC halves through
// isolate -> clear -> release together.
//
// Optional feature: define CDC_CLEAR_SEQ_RST_CLEAR_EN to make reset enter
// ISOLATE instead of IDLE, so a one-sided reset becomes a joint clear of both
// sides. That mode needs SYNC_STAGES >= 3.
module cdc_clear_sequencer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  output logic       clear_pending_o,
  output logic       isolate_o,
  input  logic       isolate_ack_i,
  output logic       clear_o,
  input  logic       clear_ack_i,
  output logic [1:0] async_state_o,
  input  logic [1:0] async_state_i
);

  // Gray-coded so that every legal transition flips exactly one bit, which
  // keeps the partner's two-bit synchronizer free of mixed-up samples.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISOLATE = 2'b01,
    ST_CLEAR   = 2'b11,
    ST_POST    = 2'b10
  } state_e;

`ifdef CDC_CLEAR_SEQ_RST_CLEAR_EN
  localparam state_e RST_STATE = ST_ISOLATE;
  localparam int     MIN_SYNC  = 3;
`else
  localparam state_e RST_STATE = ST_IDLE;
  localparam int     MIN_SYNC  = 2;
`endif

  localparam logic RST_ISOLATE = (RST_STATE != ST_IDLE);
  localparam logic RST_CLEAR   = (RST_STATE == ST_CLEAR);

  if (SYNC_STAGES < MIN_SYNC) begin : gen_sync_stages_check
    $error("cdc_clear_sequencer: SYNC_STAGES below the minimum for this build");
  end

  logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
  logic [1:0]                  partner;

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  logic   isolate_q, isolate_d;
  logic   clear_q, clear_d;
  logic   pending_q, pending_d;

  // Synchronizer shift: the partner state enters at stage 0.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_state_i};
  end

  assign partner = sync_q[SYNC_STAGES-1];

  // Next-state, pending-queue and output decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a variable unassigned, which would infer a latch.
    state_d = state_q;
    pend_d  = pend_q;

    unique case (state_q)
      ST_IDLE: begin
        if (clear_i || pend_q || partner == ST_ISOLATE) state_d = ST_ISOLATE;
      end
      ST_ISOLATE: begin
        if (isolate_ack_i && (partner == ST_ISOLATE || partner == ST_CLEAR))
          state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        if (clear_ack_i && (partner == ST_CLEAR || partner == ST_POST))
          state_d = ST_POST;
      end
      ST_POST: begin
        // Partner in POST/IDLE has released, in ISOLATE has already restarted.
        if (partner != ST_CLEAR) state_d = ST_IDLE;
        // Too late to be served by this sequence: queue a new one.
        if (clear_i) pend_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // The queued request is consumed by the sequence it starts.
    if (state_d == ST_ISOLATE && state_q != ST_ISOLATE) pend_d = 1'b0;

    isolate_d = (state_d != ST_IDLE);
    clear_d   = (state_d == ST_CLEAR);
    pending_d = isolate_d | pend_d;
  end

  // State, queue, synchronizer and registered outputs.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst_i) begin
      // NOTE: the synchronizer flops are reset too, so a fresh reset never
      // acts on a stale partner state captured before it.
      sync_q    <= '0;
      state_q   <= RST_STATE;
      pend_q    <= 1'b0;
      isolate_q <= RST_ISOLATE;
      clear_q   <= RST_CLEAR;
      pending_q <= RST_ISOLATE;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      pend_q    <= pend_d;
      isolate_q <= isolate_d;
      clear_q   <= clear_d;
      pending_q <= pending_d;
    end
  end

  assign async_state_o   = state_q;
  assign isolate_o       = isolate_q;
  assign clear_o         = clear_q;
  assign clear_pending_o = pending_q;

endmodule

// File: tb/tb_cdc_clear_sequencer.sv
// tb_cdc_clear_sequencer
// Two cross-wired sequencer instances A and B sharing one clock; each side's
// acks are its own requests delayed by one cycle. Directed scenarios with
// hand-derived cycle expectations.
module tb_cdc_clear_sequencer;

`ifdef CDC_CLEAR_SEQ_RST_CLEAR_EN
  localparam int SYNC = 3;
  localparam logic [1:0] RST_ST = 2'b01;
`else
  localparam int SYNC = 2;
  localparam logic [1:0] RST_ST = 2'b00;
`endif
  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_ISO  = 2'b01;
  localparam logic [1:0] S_CLR  = 2'b11;
  localparam logic [1:0] S_POST = 2'b10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, rst_b = 1'b1;
  logic       clr_a = 1'b0, clr_b = 1'b0;
  logic       iso_a, iso_b, cl_a, cl_b, pend_a, pend_b;
  logic       iso_ack_a = 1'b0, iso_ack_b = 1'b0;
  logic       cl_ack_a = 1'b0, cl_ack_b = 1'b0;
  logic       hold_b = 1'b0;
  logic [1:0] st_a, st_b;

  int n_checks = 0;
  int n_errors = 0;

  cdc_clear_sequencer #(.SYNC_STAGES(SYNC)) u_a (
    .clk_i(clk), .rst_i(rst_a), .clear_i(clr_a), .clear_pending_o(pend_a),
    .isolate_o(iso_a), .isolate_ack_i(iso_ack_a), .clear_o(cl_a),
    .clear_ack_i(cl_ack_a), .async_state_o(st_a), .async_state_i(st_b)
  );

  cdc_clear_sequencer #(.SYNC_STAGES(SYNC)) u_b (
    .clk_i(clk), .rst_i(rst_b), .clear_i(clr_b), .clear_pending_o(pend_b),
    .isolate_o(iso_b), .isolate_ack_i(iso_ack_b), .clear_o(cl_b),
    .clear_ack_i(cl_ack_b), .async_state_o(st_b), .async_state_i(st_a)
  );

  // Local CDC halves: acknowledge one cycle after the request.
  always @(posedge clk) begin
    iso_ack_a <= iso_a;
    cl_ack_a  <= cl_a;
    iso_ack_b <= iso_b;
    cl_ack_b  <= cl_b & ~hold_b;
  end

  // Monitors: single-bit state steps and clear_o assertions per side.
  logic [1:0] prev_a = 2'b00, prev_b = 2'b00;
  logic       prev_cl_a = 1'b0, prev_cl_b = 1'b0;
  int         gray_err = 0, rise_a = 0, rise_b = 0;
  always @(negedge clk) begin
    if (!rst_a && $countones(st_a ^ prev_a) > 1) gray_err++;
    if (!rst_b && $countones(st_b ^ prev_b) > 1) gray_err++;
    if (cl_a === 1'b1 && !prev_cl_a) rise_a++;
    if (cl_b === 1'b1 && !prev_cl_b) rise_b++;
    prev_a    = st_a;
    prev_b    = st_b;
    prev_cl_a = (cl_a === 1'b1);
    prev_cl_b = (cl_b === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_a_state(input logic [1:0] s, input string tag);
    for (int k = 0; k < 200; k++) begin
      if (st_a === s) break;
      step(1);
    end
    check(tag, {31'd0, st_a === s}, 32'd1);
  endtask

  // Waits until both sides are idle with no pending work for long enough
  // that the synchronizers have settled.
  task automatic wait_idle(input string tag);
    int quiet;
    quiet = 0;
    for (int k = 0; k < 400 && quiet < 2 * SYNC + 4; k++) begin
      step(1);
      if (st_a === S_IDLE && st_b === S_IDLE && pend_a === 1'b0 && pend_b === 1'b0 &&
          iso_a === 1'b0 && iso_b === 1'b0)
        quiet++;
      else
        quiet = 0;
    end
    check(tag, {31'd0, quiet >= 2 * SYNC + 4}, 32'd1);
  endtask

  initial begin
    int base_a, base_b, bad;

    // ---------------- reset ----------------
    step(3);
    check("rst_iso_a",  {31'd0, iso_a},  {31'd0, RST_ST != S_IDLE});
    check("rst_iso_b",  {31'd0, iso_b},  {31'd0, RST_ST != S_IDLE});
    check("rst_clr_a",  {31'd0, cl_a},   32'd0);
    check("rst_clr_b",  {31'd0, cl_b},   32'd0);
    check("rst_pend_a", {31'd0, pend_a}, {31'd0, RST_ST != S_IDLE});
    check("rst_st_a",   {30'd0, st_a},   {30'd0, RST_ST});
    check("rst_st_b",   {30'd0, st_b},   {30'd0, RST_ST});
    rst_a = 1'b0;
    rst_b = 1'b0;

`ifndef CDC_CLEAR_SEQ_RST_CLEAR_EN
    // ---------------- idle stability ----------------
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      step(1);
      if (iso_a !== 1'b0 || cl_a !== 1'b0 || pend_a !== 1'b0 || st_a !== S_IDLE) bad++;
      if (iso_b !== 1'b0 || cl_b !== 1'b0 || pend_b !== 1'b0 || st_b !== S_IDLE) bad++;
    end
    check("idle_stable", bad, 32'd0);
`endif
    wait_idle("post_reset_idle");

    // ---------------- A-initiated clear ----------------
    base_a = rise_a;
    base_b = rise_b;
    clr_a = 1'b1;                       // cycle 0
    step(1);                            // cycle 1
    clr_a = 1'b0;
    check("a_init_iso_a_c1",  {31'd0, iso_a},  32'd1);
    check("a_init_pend_a_c1", {31'd0, pend_a}, 32'd1);
    check("a_init_st_a_c1",   {30'd0, st_a},   {30'd0, S_ISO});
    check("a_init_iso_b_c1",  {31'd0, iso_b},  32'd0);
    step(SYNC);                         // cycle SYNC+1
    check("a_init_iso_b_early", {31'd0, iso_b}, 32'd0);
    step(1);                            // cycle SYNC+2
    check("a_init_iso_b",       {31'd0, iso_b}, 32'd1);
    step(SYNC);                         // cycle 2*SYNC+2
    check("a_init_clr_a_early", {31'd0, cl_a},  32'd0);
    step(1);                            // cycle 2*SYNC+3
    check("a_init_clr_a",       {31'd0, cl_a},  32'd1);
    wait_idle("a_init_done");
    check("a_init_clr_once_a", rise_a - base_a, 32'd1);
    check("a_init_clr_once_b", rise_b - base_b, 32'd1);

    // ---------------- simultaneous clear ----------------
    base_a = rise_a;
    base_b = rise_b;
    clr_a = 1'b1;
    clr_b = 1'b1;
    step(1);
    clr_a = 1'b0;
    clr_b = 1'b0;
    check("sim_iso_a", {31'd0, iso_a}, 32'd1);
    check("sim_iso_b", {31'd0, iso_b}, 32'd1);
    wait_idle("sim_done");
    check("sim_clr_once_a", rise_a - base_a, 32'd1);
    check("sim_clr_once_b", rise_b - base_b, 32'd1);

    // ---------------- late clear queued ----------------
    base_a = rise_a;
    base_b = rise_b;
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    wait_a_state(S_POST, "late_reach_post");
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    check("late_pend_a", {31'd0, pend_a}, 32'd1);
    check("late_still_post", {30'd0, st_a}, {30'd0, S_POST});
    bad = 1;
    for (int k = 0; k < 100; k++) begin
      if (pend_a !== 1'b1) bad++;
      if (st_a === S_IDLE) begin
        bad--;
        break;
      end
      step(1);
    end
    check("late_pend_held_to_idle", bad, 32'd0);
    check("late_idle_iso_a", {31'd0, iso_a}, 32'd0);
    step(1);
    check("late_restart", {30'd0, st_a}, {30'd0, S_ISO});
    wait_idle("late_done");
    check("late_clr_twice_a", rise_a - base_a, 32'd2);
    check("late_clr_twice_b", rise_b - base_b, 32'd2);

    // ---------------- ack stall ----------------
    base_a = rise_a;
    base_b = rise_b;
    hold_b = 1'b1;
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    wait_a_state(S_CLR, "stall_reach_clear");
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (st_a !== S_CLR && st_a !== S_POST) bad++;
    end
    check("stall_a_not_idle", bad, 32'd0);
    check("stall_b_clear", {31'd0, cl_b}, 32'd1);
    hold_b = 1'b0;
    wait_idle("stall_done");
    check("stall_clr_once_a", rise_a - base_a, 32'd1);
    check("stall_clr_once_b", rise_b - base_b, 32'd1);

`ifdef CDC_CLEAR_SEQ_RST_CLEAR_EN
    // ---------------- one-sided reset ----------------
    clr_a = 1'b1;
    step(1);
    clr_a = 1'b0;
    wait_a_state(S_CLR, "oneside_reach_clear");
    rst_b = 1'b1;
    step(2);
    check("oneside_rst_iso_b", {31'd0, iso_b}, 32'd1);
    check("oneside_rst_st_b",  {30'd0, st_b},  {30'd0, S_ISO});
    rst_b = 1'b0;
    step(1);
    check("oneside_after_iso_b", {31'd0, iso_b}, 32'd1);
    wait_idle("oneside_done");
`endif

    check("gray_one_bit", gray_err, 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cdc_clear_sequencer.md
# cdc_clear_sequencer

- Single-clock, one-sided clear sequencer for a two-sided clock domain crossing.
- One instance sits in each clock domain; the two instances are cross-connected through a 2-bit Gray-coded state bus.
- A clear request on either side walks both sides in lock-step through isolate → clear → release, so neither side leaks spurious or duplicated transactions.
- It drives the isolate/clear request lines of the local CDC half and consumes that half's acknowledgements.

## Interface

Parameters:
- SYNC_STAGES, default 2: flip-flop stages on the partner state input; minimum 2.

Ports:
- clk_i  input  1  clock; all logic on its rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- clear_i  input  1  local clear request; level or pulse, sampled every cycle.
- clear_pending_o  output  1  high while a sequence is running or queued.
- isolate_o  output  1  isolate request to the local CDC half (gate valid/ready).
- isolate_ack_i  input  1  local half confirms isolation.
- clear_o  output  1  clear request to the local CDC half.
- clear_ack_i  input  1  local half confirms clear.
- async_state_o  output  2  registered Gray state, sent to the partner instance.
- async_state_i  input  2  partner's async_state_o, asynchronous.

## Operation

- States, Gray-coded: IDLE=00, ISOLATE=01, CLEAR=11, POST=10. async_state_o is the state register itself.
- p = async_state_i after SYNC_STAGES synchronizer flops (reset to 00).
- Transitions:
  - IDLE→ISOLATE when clear_i or pend_q or p==ISOLATE.
  - ISOLATE→CLEAR when isolate_ack_i && p∈{ISOLATE,CLEAR}.
  - CLEAR→POST when clear_ack_i && p∈{CLEAR,POST}.
  - POST→IDLE when p∈{POST,IDLE,ISOLATE}.
- Outputs: isolate_o=1 in ISOLATE/CLEAR/POST; clear_o=1 in CLEAR only. Both are decoded from registered state (glitch-free).
- pend_q queues a clear that arrives too late to be served by the running sequence:
  - clear_i in POST sets pend_q; pend_q starts a new sequence on the cycle after IDLE is reached; pend_q clears on entering ISOLATE.
  - clear_i in ISOLATE or CLEAR is absorbed by the running sequence (no queueing).
- clear_pending_o = isolate_o | pend_q.
- Simultaneous clear_i on both sides: both enter ISOLATE; a single joint sequence follows.
- Partner starts a new sequence while the local side is in POST: local side goes POST→IDLE→ISOLATE, one cycle per step.
- State changes at most one bit per clock, except on reset (see Configuration). This makes the multi-bit synchronizer safe.

## Timing

- Reset values: state IDLE (or ISOLATE, see Configuration); pend_q=0; synchronizer=00; clear_o=0; async_state_o=00/01 matching state; isolate_o and clear_pending_o follow state.
- Local latency: clear_i high at cycle N → isolate_o=1 at N+1.
- Partner latency: a change on async_state_i is visible in p after SYNC_STAGES cycles. One extra cycle follows for the state update.
- Each handshake is level-based. Acks are sampled only in the state that waits for them; an early ack is harmless.
- Minimum sequence with 1-cycle-delayed local acks and an idle-aligned partner: isolate_o high ≥4 cycles; clear_o high ≥2 cycles.

## Configuration

- CDC_CLEAR_SEQ_RST_CLEAR_EN defined:
  - Reset forces state to ISOLATE, so a one-sided reset becomes a full clear of both sides.
  - isolate_o=1 and async_state_o=01 during and immediately after reset.
  - The partner follows from any of its states via the transition rules.
  - Requires SYNC_STAGES ≥ 3.
- Not defined: reset forces IDLE. Both sides must then be reset together; a one-sided reset mid-sequence may deadlock the partner.

## Test plan

Bench: two instances A and B cross-wired, SYNC_STAGES=2, each ack = its request delayed 1 cycle.

- **A-initiated clear.** 1-cycle clear_i pulse on A at cycle 0 → A.isolate_o=1 at cycle 1; B.isolate_o=1 at cycle 4. Both assert clear_o exactly once. Both return to IDLE with isolate_o=0 and clear_pending_o=0. async_state_o changes one bit at a time throughout.
- **Simultaneous clear.** clear_i on A and B in the same cycle → both isolate_o=1 at cycle 1. Exactly one CLEAR visit per side.
- **Late clear is queued.** clear_i on A while A is in POST → pend_q=1 and clear_pending_o stays 1. A second full sequence runs; A enters ISOLATE one cycle after reaching IDLE.
- **Ack stall.** Hold B.clear_ack_i=0 for 20 cycles → A stays in CLEAR or POST, never IDLE. Release the ack → both sides reach IDLE.
- **One-sided reset (macro defined, SYNC_STAGES=3).** rst_i on B for 2 cycles while A is in CLEAR → B.isolate_o=1 after reset. Both sides complete the sequence to IDLE with no deadlock.
- **Idle stability.** Hold clear_i=0 for 1000 cycles after reset (macro undefined) → isolate_o, clear_o and clear_pending_o stay 0; async_state_o stays 00.
